// File: rtl/and_gate_if.sv
// Operand and result bundle for the and_gate cell: the driver owns a/b, the cell owns every result.
interface and_gate_if #(
    parameter int CNT_W = 16
);
    logic             a;
    logic             b;
    logic             c;
    logic             c_q;
    logic             c_rise;
    logic [CNT_W-1:0] hi_cnt;

    modport master (
        output a,
        output b,
        input  c,
        input  c_q,
        input  c_rise,
        input  hi_cnt
    );

    modport slave (
        input  a,
        input  b,
        output c,
        output c_q,
        output c_rise,
        output hi_cnt
    );
endinterface

// File: rtl/and_gate.sv
// Two-input AND with a monitoring tap: c is combinational, c_q/c_rise/hi_cnt follow one edge later.
// No flow control; registered state clears asynchronously while c keeps tracking the operands.
module and_gate #(
    parameter int CNT_W = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    and_gate_if.slave  bus
);
    logic             w_and;
    logic             r_c_q;
    logic             r_c_rise;
    logic [CNT_W-1:0] r_hi_cnt;

    assign w_and      = bus.a & bus.b;
    assign bus.c      = w_and;
    assign bus.c_q    = r_c_q;
    assign bus.c_rise = r_c_rise;
    assign bus.hi_cnt = r_hi_cnt;

    // r_c_q resets to 0, so the first high sample after reset release is a rise.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c_q    <= 1'b0;
            r_c_rise <= 1'b0;
            r_hi_cnt <= '0;
        end else begin
            r_c_q    <= w_and;
            r_c_rise <= w_and & ~r_c_q;
            if (w_and && (r_hi_cnt != {CNT_W{1'b1}}))
                r_hi_cnt <= r_hi_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_and_gate.sv
// Scoreboard bench for and_gate: stimulus queues hand-computed expectations, a monitor compares them.
module tb_and_gate;
    localparam int CNT_W = 3;

    typedef struct {
        string      tag;
        logic       c;
        logic       cq;
        logic       rise;
        logic [2:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb_q[$];
    int   n_push;
    int   n_pop;
    int   n_checks;
    int   n_pass;

    and_gate_if #(.CNT_W(CNT_W)) bus ();

    and_gate #(.CNT_W(CNT_W)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic c, input logic cq,
                        input logic rise, input int cnt);
        exp_t e;
        e.tag  = tag;
        e.c    = c;
        e.cq   = cq;
        e.rise = rise;
        e.cnt  = 3'(cnt);
        sb_q.push_back(e);
        n_push++;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares the DUT outputs whenever an expectation is waiting.
    initial begin
        exp_t e;
        forever begin
            wait (n_push > n_pop);
            e = sb_q.pop_front();
            n_pop++;
            check({e.tag, ".c"},      {7'd0, bus.c},      {7'd0, e.c});
            check({e.tag, ".c_q"},    {7'd0, bus.c_q},    {7'd0, e.cq});
            check({e.tag, ".c_rise"}, {7'd0, bus.c_rise}, {7'd0, e.rise});
            check({e.tag, ".hi_cnt"}, {5'd0, bus.hi_cnt}, {5'd0, e.cnt});
        end
    end

    initial begin
        logic [1:0] tt [4];
        logic       tt_c [4];
        n_push = 0; n_pop = 0; n_checks = 0; n_pass = 0;
        tt[0] = 2'b00; tt[1] = 2'b01; tt[2] = 2'b10; tt[3] = 2'b11;
        tt_c[0] = 1'b0; tt_c[1] = 1'b0; tt_c[2] = 1'b0; tt_c[3] = 1'b1;

        rst_n = 1'b0; bus.a = 1'b0; bus.b = 1'b0;
        #1 push("reset", 0, 0, 0, 0);

        // Truth table while held in reset: c must ignore reset.
        for (int i = 0; i < 4; i++) begin
            {bus.a, bus.b} = tt[i];
            #1 push($sformatf("tt%0d", i), tt_c[i], 0, 0, 0);
            #9;
        end

        @(negedge clk); bus.a = 1'b0; bus.b = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1 push("release", 0, 0, 0, 0);

        @(negedge clk); bus.a = 1'b1; bus.b = 1'b1;
        #1 push("pre_edge", 1, 0, 0, 0);
        @(posedge clk); #1 push("first_rise", 1, 1, 1, 1);
        for (int i = 2; i <= 4; i++) begin
            @(posedge clk); #1 push($sformatf("hold%0d", i), 1, 1, 0, i);
        end

        @(negedge clk); #2 rst_n = 1'b0;
        #1 push("async_rst", 1, 0, 0, 0);

        @(negedge clk); rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1 push($sformatf("sat%0d", i), 1, 1, (i == 1), (i > 7) ? 7 : i);
        end

        @(negedge clk); bus.a = 1'b0;
        @(posedge clk); #1 push("glitch_pre", 0, 0, 0, 7);
        #2 bus.a = 1'b1;
        #1 push("glitch_hi", 1, 0, 0, 7);
        wait (n_pop == n_push);
        bus.a = 1'b0;
        #1 push("glitch_lo", 0, 0, 0, 7);
        @(posedge clk); #1 push("glitch_post", 0, 0, 0, 7);

        @(negedge clk); #2 rst_n = 1'b0;
        #1 push("rst2", 0, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bus.a = (i % 2 == 0); bus.b = 1'b1;
            @(posedge clk);
            #1 push($sformatf("toggle%0d", i), (i % 2 == 0), (i % 2 == 0), (i % 2 == 0), i / 2 + 1);
        end

        for (int i = 0; i < 100 && n_pop < n_push; i++) #1;
        if (n_pop < n_push) begin
            n_checks++;
            $display("FAIL scoreboard_drain: popped %0d expected %0d", n_pop, n_push);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/and_gate.md
Name: and_gate

Overview:
- Two-input logical AND cell with a zero-latency combinational output `c = a & b`.
- Also provides clocked companions: a registered copy of the AND result, a single-cycle rising-edge pulse, and a saturating count of cycles where the result is high.
- Used as a basic gate primitive plus a monitoring tap in glue logic.
- The combinational path is independent of clock and reset.

Parameters:
- CNT_W, 16, width of the high-cycle counter `hi_cnt` (minimum 1).

Ports:
- clk  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset for all registered state.
- a  input  1  operand A.
- b  input  1  operand B.
- c  output  1  combinational AND of `a` and `b`.
- c_q  output  1  `c` registered on the `clk` rising edge.
- c_rise  output  1  one-cycle pulse when `c_q` goes 0 to 1.
- hi_cnt  output  CNT_W  saturating count of clock edges sampling `c` = 1.

Behaviour:
- Clock and reset:
  - One clock (`clk`).
  - Reset is asynchronous and active-low (`rst_n`).
- Combinational output `c`:
  - `c = a & b` at all times, with no clock involvement and no reset gating.
  - Truth table: 00 gives 0; 01 gives 0; 10 gives 0; 11 gives 1.
  - `c` must settle within the same delta as an input change.
  - Any X or Z on an input propagates per standard 4-state AND semantics, so 0 & X = 0.
- Reset:
  - `rst_n` low immediately forces `c_q` = 0, `c_rise` = 0 and `hi_cnt` = 0, regardless of `clk`.
  - Reset does not affect `c`.
  - Release is synchronous to the next `clk` rising edge; the first capture happens on the first edge with `rst_n` high.
- Registered output `c_q`:
  - On each `clk` rising edge with `rst_n` high: `c_q <= a & b`.
  - Latency is 1 cycle from input to `c_q`.
- Edge pulse `c_rise`:
  - Registered: `c_rise <= (a & b) & ~c_q` on each edge.
  - It is high for exactly one cycle, in the cycle in which `c_q` first becomes 1.
  - It stays 0 while `c_q` remains 1.
  - The first rise after reset release counts as a rise, because `c_q` resets to 0.
- Counter `hi_cnt`:
  - On each edge with `rst_n` high, if `a & b` = 1 and `hi_cnt` is not all-ones, increment by 1.
  - It saturates at 2^CNT_W − 1 and never wraps.
  - When `a & b` = 0 it holds its value.
  - It is cleared only by reset.
- Glitches: input pulses shorter than a clock period are visible on `c` but are captured by `c_q`, `c_rise` and `hi_cnt` only if present at a rising edge.
- Reset mid-operation: all registered outputs clear immediately; `c` continues tracking the inputs.

Test Plan:
- Truth table sweep: apply (a,b) = 00, 01, 10, 11 at 10 ns intervals and sample `c` 1 ns after each change -> `c` = 0, 0, 0, 1.
- Registered path: with `rst_n` = 1, set a=1, b=1 just before an edge -> `c_q` = 1 after that edge and `c_rise` = 1 for exactly that one cycle. Holding 11 for 3 more cycles -> `c_rise` = 0 and `hi_cnt` = 4.
- Async reset: with `hi_cnt` = 4 and `c_q` = 1, drop `rst_n` between edges -> `c_q`, `c_rise` and `hi_cnt` go to 0 immediately, while `c` stays 1 with inputs at 11.
- Saturation: with CNT_W=3, hold a=b=1 for 10 cycles -> `hi_cnt` reaches 7 and stays 7.
- Toggle pattern: alternate between 11 and 10 every cycle for 6 cycles, starting from 11 -> `c_rise` pulses 3 times and `hi_cnt` = 3.
- Sub-cycle glitch: drive a 1 ns pulse of 11 between edges -> `c` shows the pulse, while `c_q`, `c_rise` and `hi_cnt` remain unchanged.
